// File: rtl/rmon_ctr_pkg.sv
// -----------------------------------------------------------------------------
// rmon_ctr_pkg
// Shared definitions for the RMON statistics counter store: controller state
// encoding and default geometry used as parameter defaults by the RTL.
// -----------------------------------------------------------------------------
package rmon_ctr_pkg;

    // Default counter geometry
    localparam int unsigned DEF_DW = 32;  // counter width
    localparam int unsigned DEF_AW = 6;   // address width, DEPTH = 2**AW
    localparam int unsigned DEF_IW = 16;  // increment width

    // Controller state: zero sweep after reset, then normal operation
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : rmon_ctr_pkg

// File: rtl/rmon_ctr_sdpram.sv
// -----------------------------------------------------------------------------
// rmon_ctr_sdpram
// Simple dual-port RAM, one write port and one synchronous read port,
// DW x 2**AW, no reset. A read and a write to the same address on the same
// edge return the old contents.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address (AW)
//   i_wdata  in   write data (DW)
//   i_raddr  in   read address (AW), sampled every rising edge
//   o_rdata  out  read data (DW), valid the cycle after the address edge
// -----------------------------------------------------------------------------
module rmon_ctr_sdpram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Storage array; non-blocking read gives read-old on collision
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : rmon_ctr_sdpram

// File: rtl/rmon_ctr_ram.sv
// -----------------------------------------------------------------------------
// rmon_ctr_ram
// RMON statistics counter store. The RMON side posts increment ops
// (address + delta) which are applied by an internal read-modify-write pipe,
// optionally saturating. The CPU side reads counters with optional
// clear-on-read. All entries are swept to zero after reset.
// Ports:
//   clk            in   clock
//   rst_n          in   asynchronous active-low reset
//   i_inc_valid    in   increment request
//   i_inc_addr     in   counter index (AW)
//   i_inc_value    in   delta (IW), zero-extended to DW
//   o_inc_ready    out  increment accepted when valid & ready at a rising edge
//   i_cpu_rd_req   in   level request, held until o_cpu_rd_ack
//   i_cpu_rd_addr  in   counter index (AW), stable while req is high
//   i_cpu_rd_clr   in   write 0 after reading
//   o_cpu_rd_ack   out  one-cycle pulse, read data valid
//   o_cpu_rd_data  out  counter value (DW), held until the next ack
//   o_init_done    out  post-reset zero sweep complete
// -----------------------------------------------------------------------------
module rmon_ctr_ram
    import rmon_ctr_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned IW       = DEF_IW,
    parameter int unsigned SATURATE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc_valid,
    input  logic [AW-1:0] i_inc_addr,
    input  logic [IW-1:0] i_inc_value,
    output logic          o_inc_ready,
    input  logic          i_cpu_rd_req,
    input  logic [AW-1:0] i_cpu_rd_addr,
    input  logic          i_cpu_rd_clr,
    output logic          o_cpu_rd_ack,
    output logic [DW-1:0] o_cpu_rd_data,
    output logic          o_init_done
);

    localparam int unsigned DEPTH = 2 ** AW;

    // Controller
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_sweep_we;
    logic          w_run;
    logic [AW-1:0] r_sweep_addr;
    logic          w_sweep_last;
    logic          r_init_done;

    // Arbitration
    logic          r_cpu_busy;
    logic          w_cpu_acc;
    logic          w_inc_ready;
    logic          w_inc_acc;
    logic [AW-1:0] w_rd_addr;

    // Stage 1 op registers
    logic          r_s1_valid;
    logic          r_s1_cpu;
    logic          r_s1_clr;
    logic [AW-1:0] r_s1_addr;
    logic [IW-1:0] r_s1_delta;

    // Datapath
    logic [DW-1:0] w_ram_rdata;
    logic [DW-1:0] w_cur;
    logic [DW:0]   w_sum;
    logic [DW-1:0] w_inc_new;
    logic [DW-1:0] w_op_new;
    logic          w_op_we;

    // RAM write port and last-write register
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic          r_lw_valid;
    logic [AW-1:0] r_lw_addr;
    logic [DW-1:0] r_lw_data;

    // CPU response
    logic          r_cpu_rd_ack;
    logic [DW-1:0] r_cpu_rd_data;

    assign w_sweep_last = (r_sweep_addr == AW'(DEPTH - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave INIT once the last entry has been zeroed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_sweep_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_sweep_we = 1'b0;
        w_run      = 1'b0;
        case (r_state)
            ST_INIT: w_sweep_we = 1'b1;
            ST_RUN:  w_run      = 1'b1;
            default: w_sweep_we = 1'b0;
        endcase
    end

    // Zero sweep address and completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep_addr <= '0;
            r_init_done  <= 1'b0;
        end else if (w_sweep_we) begin
            r_sweep_addr <= r_sweep_addr + AW'(1);
            if (w_sweep_last) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // CPU has priority; a pending CPU request blocks increments for one cycle
    assign w_cpu_acc   = w_run & i_cpu_rd_req & ~r_cpu_busy;
    assign w_inc_ready = w_run & ~(i_cpu_rd_req & ~r_cpu_busy);
    assign w_inc_acc   = i_inc_valid & w_inc_ready;
    assign w_rd_addr   = w_cpu_acc ? i_cpu_rd_addr : i_inc_addr;

    // Busy spans the ack cycle so a still-high request is not re-accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_busy <= 1'b0;
        end else if (w_cpu_acc) begin
            r_cpu_busy <= 1'b1;
        end else if (r_cpu_rd_ack) begin
            r_cpu_busy <= 1'b0;
        end
    end

    // Stage 1 op capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_cpu   <= 1'b0;
            r_s1_clr   <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_delta <= '0;
        end else begin
            r_s1_valid <= w_cpu_acc | w_inc_acc;
            r_s1_cpu   <= w_cpu_acc;
            r_s1_clr   <= i_cpu_rd_clr;
            r_s1_addr  <= w_rd_addr;
            r_s1_delta <= i_inc_value;
        end
    end

    rmon_ctr_sdpram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_rdata)
    );

    // The RAM read coincided with the previous write edge, so take that
    // write's data when it hit the same entry
    assign w_cur = (r_lw_valid && (r_lw_addr == r_s1_addr)) ? r_lw_data : w_ram_rdata;

    // Add in DW+1 bits; carry-out either clamps or is dropped
    assign w_sum     = {1'b0, w_cur} + (DW + 1)'(r_s1_delta);
    assign w_inc_new = (w_sum[DW] && (SATURATE != 0)) ? {DW{1'b1}} : w_sum[DW-1:0];
    assign w_op_new  = r_s1_cpu ? '0 : w_inc_new;
    assign w_op_we   = r_s1_valid & (~r_s1_cpu | r_s1_clr);

    // Sweep and pipe writes never overlap: no ops are accepted during INIT
    assign w_we    = w_sweep_we | w_op_we;
    assign w_waddr = w_sweep_we ? r_sweep_addr : r_s1_addr;
    assign w_wdata = w_sweep_we ? '0 : w_op_new;

    // Last-write register for forwarding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lw_valid <= 1'b0;
            r_lw_addr  <= '0;
            r_lw_data  <= '0;
        end else begin
            r_lw_valid <= w_we;
            r_lw_addr  <= w_waddr;
            r_lw_data  <= w_wdata;
        end
    end

    // CPU response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rd_ack  <= 1'b0;
            r_cpu_rd_data <= '0;
        end else begin
            r_cpu_rd_ack <= r_s1_valid & r_s1_cpu;
            if (r_s1_valid && r_s1_cpu) begin
                r_cpu_rd_data <= w_cur;
            end
        end
    end

    assign o_inc_ready   = w_inc_ready;
    assign o_cpu_rd_ack  = r_cpu_rd_ack;
    assign o_cpu_rd_data = r_cpu_rd_data;
    assign o_init_done   = r_init_done;

endmodule : rmon_ctr_ram

// File: tb/tb_rmon_ctr_ram.sv
// -----------------------------------------------------------------------------
// tb_rmon_ctr_ram
// Two 8-bit counter stores (saturating and wrapping) share one stimulus
// stream; a reference model applies every accepted op atomically, in accept
// order, to plain integer arrays.
// -----------------------------------------------------------------------------
module tb_rmon_ctr_ram;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned IW    = 8;
    localparam int unsigned DEPTH = 64;

    logic          clk;
    logic          rst_n;
    logic          inc_valid;
    logic [AW-1:0] inc_addr;
    logic [IW-1:0] inc_value;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_clr;

    logic          s_ready, w_ready;
    logic          s_ack, w_ack;
    logic [DW-1:0] s_data, w_data;
    logic          s_done, w_done;

    rmon_ctr_ram #(.DW(DW), .AW(AW), .IW(IW), .SATURATE(1)) u_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_inc_valid   (inc_valid),
        .i_inc_addr    (inc_addr),
        .i_inc_value   (inc_value),
        .o_inc_ready   (s_ready),
        .i_cpu_rd_req  (cpu_req),
        .i_cpu_rd_addr (cpu_addr),
        .i_cpu_rd_clr  (cpu_clr),
        .o_cpu_rd_ack  (s_ack),
        .o_cpu_rd_data (s_data),
        .o_init_done   (s_done)
    );

    rmon_ctr_ram #(.DW(DW), .AW(AW), .IW(IW), .SATURATE(0)) u_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_inc_valid   (inc_valid),
        .i_inc_addr    (inc_addr),
        .i_inc_value   (inc_value),
        .o_inc_ready   (w_ready),
        .i_cpu_rd_req  (cpu_req),
        .i_cpu_rd_addr (cpu_addr),
        .i_cpu_rd_clr  (cpu_clr),
        .o_cpu_rd_ack  (w_ack),
        .o_cpu_rd_data (w_data),
        .o_init_done   (w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int m_sat  [DEPTH];
    int m_wrap [DEPTH];
    bit run;
    int init_cnt;
    bit cpu_taken;
    bit pend_ack;
    int pend_s, pend_w;
    bit exp_ack;
    int exp_s, exp_w;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int add_sat(input int c, input int d);
        return (c + d > 255) ? 255 : c + d;
    endfunction

    function automatic int add_wrap(input int c, input int d);
        return (c + d) % 256;
    endfunction

    task automatic model_clear();
        run       = 1'b0;
        init_cnt  = 0;
        cpu_taken = 1'b0;
        pend_ack  = 1'b0;
        exp_ack   = 1'b0;
        pend_s    = 0;
        pend_w    = 0;
        exp_s     = 0;
        exp_w     = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_sat[i]  = 0;
            m_wrap[i] = 0;
        end
    endtask

    // One clock: check ready with the current inputs, advance the model at
    // the edge, then check the registered outputs
    task automatic tick();
        bit exp_ready;
        bit cpu_acc;
        bit inc_acc;
        #1;
        exp_ready = run && !(cpu_req && !cpu_taken);
        chk("inc_ready_sat",  32'(s_ready), 32'(exp_ready));
        chk("inc_ready_wrap", 32'(w_ready), 32'(exp_ready));
        cpu_acc = run && cpu_req && !cpu_taken;
        inc_acc = inc_valid && exp_ready;
        @(posedge clk);
        exp_ack = pend_ack;
        if (pend_ack) begin
            exp_s = pend_s;
            exp_w = pend_w;
        end
        pend_ack = cpu_acc;
        if (cpu_acc) begin
            pend_s    = m_sat[cpu_addr];
            pend_w    = m_wrap[cpu_addr];
            cpu_taken = 1'b1;
            if (cpu_clr) begin
                m_sat[cpu_addr]  = 0;
                m_wrap[cpu_addr] = 0;
            end
        end
        if (inc_acc) begin
            m_sat[inc_addr]  = add_sat(m_sat[inc_addr], int'(inc_value));
            m_wrap[inc_addr] = add_wrap(m_wrap[inc_addr], int'(inc_value));
        end
        if (!run) begin
            init_cnt++;
            if (init_cnt == DEPTH) run = 1'b1;
        end
        #1;
        chk("ack_sat",   32'(s_ack),  32'(exp_ack));
        chk("ack_wrap",  32'(w_ack),  32'(exp_ack));
        chk("data_sat",  32'(s_data), 32'(exp_s));
        chk("data_wrap", 32'(w_data), 32'(exp_w));
        chk("done_sat",  32'(s_done), 32'(run));
        chk("done_wrap", 32'(w_done), 32'(run));
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        inc_valid = 1'b0;
        cpu_req   = 1'b0;
        cpu_clr   = 1'b0;
        model_clear();
        #1;
        chk("rst_ack",   32'(s_ack | w_ack), 32'(0));
        chk("rst_done",  32'(s_done | w_done), 32'(0));
        chk("rst_data",  32'(s_data | w_data), 32'(0));
        chk("rst_ready", 32'(s_ready | w_ready), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_ack", 32'(s_ack | w_ack), 32'(0));
        rst_n = 1'b1;
    endtask

    task automatic run_init();
        for (int i = 0; i < DEPTH; i++) tick();
    endtask

    task automatic inc(input int a, input int v);
        inc_valid = 1'b1;
        inc_addr  = AW'(a);
        inc_value = IW'(v);
        tick();
        inc_valid = 1'b0;
    endtask

    task automatic cpu_read(input int a, input bit clr);
        int k;
        cpu_req  = 1'b1;
        cpu_addr = AW'(a);
        cpu_clr  = clr;
        k = 0;
        do begin
            tick();
            k++;
        end while (!exp_ack && k < 8);
        cpu_req   = 1'b0;
        cpu_taken = 1'b0;
        tick();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b1;
        inc_valid = 1'b0;
        inc_addr  = '0;
        inc_value = '0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_clr   = 1'b0;
        #2;

        // Reset release and zero sweep, then read the last entry
        apply_reset();
        run_init();
        cpu_read(63, 1'b0);
        chk("t1_rd63", 32'(s_data), 32'(0));

        // Back-to-back increments to one address, read right behind them
        inc(5, 1);
        inc(5, 1);
        inc(5, 1);
        cpu_read(5, 1'b0);
        chk("t2_rd5", 32'(s_data), 32'(3));

        // Saturation versus wrap
        inc(2, 200);
        inc(2, 100);
        cpu_read(2, 1'b0);
        chk("t3_sat",  32'(s_data), 32'(255));
        chk("t3_wrap", 32'(w_data), 32'(44));

        // Clear-on-read
        inc(7, 10);
        cpu_read(7, 1'b1);
        chk("t4_clr_rd", 32'(s_data), 32'(10));
        cpu_read(7, 1'b0);
        chk("t4_after_clr", 32'(w_data), 32'(0));

        // Increment held against a CPU request to the same address
        inc_valid = 1'b1;
        inc_addr  = AW'(9);
        inc_value = IW'(1);
        cpu_req   = 1'b1;
        cpu_addr  = AW'(9);
        cpu_clr   = 1'b0;
        tick();
        tick();
        chk("t5_cpu_first", 32'(s_data), 32'(0));
        cpu_req   = 1'b0;
        cpu_taken = 1'b0;
        tick();
        tick();
        inc_valid = 1'b0;
        cpu_read(9, 1'b0);
        chk("t5_no_drop", 32'(s_data), 32'(3));

        // Randomized mixed traffic
        for (int c = 0; c < 2000; c++) begin
            if (cpu_req && exp_ack) begin
                cpu_req   = 1'b0;
                cpu_taken = 1'b0;
            end else if (!cpu_req && !exp_ack && $urandom_range(0, 3) == 0) begin
                cpu_req  = 1'b1;
                cpu_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                       : AW'($urandom_range(0, 63));
                cpu_clr  = 1'($urandom_range(0, 1));
            end
            inc_valid = ($urandom_range(0, 3) != 0);
            inc_addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                    : AW'($urandom_range(0, 63));
            inc_value = ($urandom_range(0, 9) == 0) ? IW'($urandom_range(0, 255))
                                                    : IW'($urandom_range(0, 7));
            tick();
        end
        inc_valid = 1'b0;
        if (cpu_req) begin
            while (!exp_ack) tick();
            cpu_req   = 1'b0;
            cpu_taken = 1'b0;
            tick();
        end

        // Final sweep of every counter against the model
        for (int a = 0; a < DEPTH; a++) cpu_read(a, 1'b0);

        // Reset with an ack pending
        cpu_req  = 1'b1;
        cpu_addr = AW'(5);
        cpu_clr  = 1'b0;
        tick();
        apply_reset();
        run_init();
        for (int a = 0; a < DEPTH; a++) begin
            cpu_read(a, 1'b0);
            chk("t6_zero", 32'(s_data | w_data), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rmon_ctr_ram
